uart_tx: RTL and testbench
==========================

# uart_tx

UART transmit engine: accepts one 8-bit parallel word per handshake and serialises it onto `TX_OUT` as start bit, 8 data bits LSB first, optional parity bit and one stop bit. Each bit lasts `Prescale` clock cycles, so the same `Prescale` value that configures the oversampling receiver produces the matching line rate from this block. It sits opposite the receive path on the serial line and is fed by the system-side data source.

## Interface

Parameters:
- none; the data width is fixed at 8 bits.

Ports:
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `P_DATA`  in  8  parallel word to transmit.
- `Data_Valid`  in  1  request to transmit `P_DATA`; sampled only while `Busy`=0.
- `PAR_EN`  in  1  1 = a parity bit is inserted between the data bits and the stop bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `Prescale`  in  6  bit period in `CLK` cycles; 0 encodes 64.
- `TX_OUT`  out  1  serial line, idles high; registered.
- `Busy`  out  1  a frame is in progress; registered.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- **Accept.** In IDLE with `Data_Valid`=1 the block latches `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale`. It computes parity = ^P_DATA XOR `PAR_TYP` and enters START. Input changes after acceptance do not affect the frame in progress.
- **Bit period.** A 6-bit edge counter runs 0..(latched Prescale−1) using 6-bit wrap arithmetic, so Prescale=0 gives 64 cycles. The state advances when the counter reaches terminal count, and the counter then returns to 0.
- **START.** `TX_OUT`=0 for one bit period, then go to DATA.
- **DATA.** A 3-bit bit counter selects the bit, starting at data[0] (LSB first). After bit 7, go to PARITY if the latched `PAR_EN`=1, else go to STOP.
- **PARITY.** `TX_OUT` = computed parity bit for one bit period, then go to STOP.
- **STOP.** `TX_OUT`=1 for one bit period, then go to IDLE.
- **Busy.** `Busy`=1 in every state except IDLE. `Data_Valid` is ignored while `Busy`=1; there is no queuing and no error flag.
- **Reset.** `RST` in any state, including mid-frame, aborts the frame. On the next edge: state IDLE, `TX_OUT`=1, `Busy`=0, both counters 0, and the latched data cleared. No truncated stop bit is emitted.

## Timing

- **Reset values:** `TX_OUT`=1, `Busy`=0.
- **Latency.** `Data_Valid` is sampled high in IDLE at edge N. `TX_OUT` falls and `Busy` rises at edge N+1; both outputs are registered.
- **Frame length.** `Busy` stays high for exactly F×P cycles, where P is the effective prescale and F = 11 with parity or 10 without.
- **Frame end.** The first cycle with `Busy`=0 after a frame is IDLE, and `TX_OUT` is 1 there.
- **Back-to-back frames.** If `Data_Valid` is held high, the next frame is accepted in that first IDLE cycle. Its start bit begins one cycle later. This gives a minimum gap of exactly 1 idle-high cycle between frames.
- **Bit boundaries.** `TX_OUT` changes only on bit-period boundaries; there are no glitches inside a bit period.
- **Simultaneous `RST` and `Data_Valid`:** reset wins and nothing is accepted.

## Test plan

- **Reset idle.** Assert `RST` for 3 cycles, then release with `Data_Valid`=0 for 100 cycles. Required: `TX_OUT`=1 and `Busy`=0 throughout.
- **Basic frame, no parity.** `P_DATA`=8'hA5, PAR_EN=0, Prescale=8, one-cycle `Data_Valid`. Required: line sequence 0,1,0,1,0,0,1,0,1,1, each value held 8 cycles. `Busy` is high for exactly 80 cycles and first rises 1 cycle after the accept edge.
- **Parity, both types.** `P_DATA`=8'h03, PAR_EN=1, Prescale=16.
  - PAR_TYP=0: parity bit = 0.
  - PAR_TYP=1: parity bit = 1.
  - In both cases `Busy` is high for 176 cycles.
- **Held request and mid-frame input changes.** `Data_Valid` held high with `P_DATA` changed mid-frame from 8'h55 to 8'hFF. Required:
  - The first frame carries 8'h55.
  - The mid-frame change has no effect on the first frame.
  - The second frame carries 8'hFF and its start bit begins after exactly 1 idle-high cycle.
- **Prescale=0.** Send 8'h00 with Prescale=0 and PAR_EN=0. Required: each bit lasts 64 cycles and `Busy` is high for 640 cycles.
- **Reset mid-frame.** Assert `RST` during data bit 3 of an 8'h00 frame. Required: `TX_OUT`=1 and `Busy`=0 on the next edge. A following request then produces a complete, correct frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Latency: TX_OUT drops and Busy rises on the edge after Data_Valid is seen in IDLE.
// Backpressure: Busy=1 for the whole frame; Data_Valid is ignored (not queued) while busy.
module uart_tx (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] P_DATA,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [5:0] Prescale,
    output logic       TX_OUT,
    output logic       Busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;       // cycle position inside the current bit period
    logic [2:0] bit_q, bit_d;       // data bit index
    logic [7:0] data_q, data_d;
    logic       par_en_q, par_en_d;
    logic       par_q, par_d;       // parity bit, computed once at accept time
    logic [5:0] pre_q, pre_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;

    logic [5:0] term_cnt;
    logic       bit_end;
    logic [2:0] bit_nxt;

    // 6-bit wrap makes Prescale=0 terminate at 63, i.e. a 64-cycle bit
    assign term_cnt = pre_q - 6'd1;
    assign bit_end  = (cnt_q == term_cnt);
    assign bit_nxt  = bit_q + 3'd1;

    // Next-state and next-output logic; outputs are computed one cycle early so they can be registered
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        pre_d    = pre_q;
        tx_d     = tx_q;
        busy_d   = busy_q;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? 6'd0 : cnt_q + 6'd1;
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (Data_Valid) begin
                    data_d   = P_DATA;
                    par_en_d = PAR_EN;
                    par_d    = (^P_DATA) ^ PAR_TYP;
                    pre_d    = Prescale;
                    cnt_d    = 6'd0;
                    bit_d    = 3'd0;
                    state_d  = START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = data_q[bit_nxt];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress without a stop bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            bit_q    <= 3'd0;
            data_q   <= 8'd0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            pre_q    <= 6'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            pre_q    <= pre_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: scoreboard of expected frames checked bit by bit on the serial line.
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: stimulus waits on monitor frame count with cycle budgets.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    typedef struct {
        logic [7:0] d;
        logic       en;
        logic       typ;
        logic [5:0] pre;
    } exp_t;

    exp_t exp_q[$];

    int checks      = 0;
    int errors      = 0;
    int frames_done = 0;
    int idle_cnt    = 0;
    int last_gap    = 0;
    int last_par    = 0;
    bit mon_en      = 1'b1;
    bit prev_busy   = 1'b0;

    uart_tx dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic en, input logic typ,
                        input logic [5:0] pre, input bit push);
        exp_t e;
        @(posedge CLK); #1;
        P_DATA     = d;
        PAR_EN     = en;
        PAR_TYP    = typ;
        Prescale   = pre;
        Data_Valid = 1'b1;
        if (push) begin
            e.d = d; e.en = en; e.typ = typ; e.pre = pre;
            exp_q.push_back(e);
        end
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int cyc;
        cyc = 0;
        while (frames_done < n && cyc < budget) begin
            @(posedge CLK); #2;
            cyc++;
        end
        if (frames_done < n) chk("frame_timeout", frames_done, n);
    endtask

    // Monitor: decodes each frame against the scoreboard head
    initial begin
        forever begin
            @(posedge CLK); #1;
            if (mon_en && Busy === 1'b1 && !prev_busy) begin
                last_gap = idle_cnt;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    prev_busy = 1'b1;
                end else begin
                    exp_t e;
                    logic bits [0:10];
                    int f, p, bad, busy_bad;
                    e = exp_q.pop_front();
                    f = e.en ? 11 : 10;
                    p = (e.pre == 6'd0) ? 64 : int'(e.pre);
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[i+1] = e.d[i];
                    bits[9]  = e.en ? ((^e.d) ^ e.typ) : 1'b1;
                    bits[10] = 1'b1;
                    bad = 0;
                    busy_bad = 0;
                    for (int b = 0; b < f; b++) begin
                        for (int c = 0; c < p; c++) begin
                            if (!(b == 0 && c == 0)) begin
                                @(posedge CLK); #1;
                            end
                            if (TX_OUT !== bits[b]) bad++;
                            if (Busy !== 1'b1) busy_bad++;
                            if (c == 0) begin
                                chk($sformatf("bit%0d_of_%02h", b, e.d), int'(TX_OUT), int'(bits[b]));
                                if (e.en && b == 9) last_par = int'(TX_OUT);
                            end
                        end
                    end
                    chk("bit_stable", bad, 0);
                    chk("busy_held", busy_bad, 0);
                    @(posedge CLK); #1;
                    chk("end_busy", int'(Busy), 0);
                    chk("end_tx", int'(TX_OUT), 1);
                    prev_busy = Busy;
                    idle_cnt = 1;
                    frames_done++;
                end
            end else begin
                if (Busy !== 1'b1) idle_cnt++;
                prev_busy = (Busy === 1'b1);
            end
        end
    end

    initial begin
        int bad_tx, bad_busy;
        RST = 1'b1; Data_Valid = 1'b0; P_DATA = 8'h00;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;

        // Reset and idle line
        @(posedge CLK); #1;
        chk("rst_tx", int'(TX_OUT), 1);
        chk("rst_busy", int'(Busy), 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        bad_tx = 0; bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            if (TX_OUT !== 1'b1) bad_tx++;
            if (Busy !== 1'b0) bad_busy++;
        end
        chk("idle_tx", bad_tx, 0);
        chk("idle_busy", bad_busy, 0);

        // Basic frame, no parity, with latency check
        chk("pre_accept_busy", int'(Busy), 0);
        send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b1);
        chk("lat_busy", int'(Busy), 1);
        chk("lat_tx", int'(TX_OUT), 0);
        wait_frames(1, 200);

        // Parity, even then odd
        send(8'h03, 1'b1, 1'b0, 6'd16, 1'b1);
        wait_frames(2, 400);
        chk("even_parity_bit", last_par, 0);
        send(8'h03, 1'b1, 1'b1, 6'd16, 1'b1);
        wait_frames(3, 400);
        chk("odd_parity_bit", last_par, 1);

        // Held request with mid-frame data change
        begin
            exp_t e;
            send_hold: begin
                @(posedge CLK); #1;
                P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
                Data_Valid = 1'b1;
                e.d = 8'h55; e.en = 1'b0; e.typ = 1'b0; e.pre = 6'd8;
                exp_q.push_back(e);
            end
            repeat (20) @(posedge CLK);
            #1 P_DATA = 8'hFF;
            e.d = 8'hFF;
            exp_q.push_back(e);
            wait_frames(4, 200);
            @(posedge CLK); #1;
            Data_Valid = 1'b0;
            wait_frames(5, 200);
            chk("b2b_gap", last_gap, 1);
        end

        // Prescale 0 means 64-cycle bits
        send(8'h00, 1'b0, 1'b0, 6'd0, 1'b1);
        wait_frames(6, 1000);

        // Reset during data bit 3, with a simultaneous request
        mon_en = 1'b0;
        send(8'h00, 1'b0, 1'b0, 6'd4, 1'b0);
        repeat (17) @(posedge CLK);
        #1;
        chk("mid_busy_before_rst", int'(Busy), 1);
        RST = 1'b1;
        Data_Valid = 1'b1;
        P_DATA = 8'h3C;
        @(posedge CLK); #1;
        chk("abort_tx", int'(TX_OUT), 1);
        chk("abort_busy", int'(Busy), 0);
        RST = 1'b0;
        Data_Valid = 1'b0;
        @(posedge CLK); #1;
        chk("rst_wins_busy", int'(Busy), 0);
        mon_en = 1'b1;
        send(8'hC3, 1'b1, 1'b1, 6'd4, 1'b1);
        wait_frames(7, 200);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
